// File: rtl/image_store_ring_ctrl_pkg.sv
// Shared types and constants for the image store ring controller.
// Holds the FSM encoding, the fixed per-command image count and the default index width.
package image_store_ring_ctrl_pkg;

    localparam int unsigned DEFAULT_BUF_W = 2;
    localparam int unsigned CMD_IMAGE_CNT = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

endpackage

// File: rtl/image_store_ring_next_idx.sv
// Picks the next ring buffer to write: the successor of wr_idx, advanced once more
// if that successor is the buffer the reader is holding. Wrap uses a compare, not a modulo.
module image_store_ring_next_idx
    import image_store_ring_ctrl_pkg::*;
#(
    parameter int BUF_W = DEFAULT_BUF_W
) (
    input  logic [BUF_W-1:0] wr_idx,
    input  logic [BUF_W-1:0] n,
    input  logic             rd_lock,
    input  logic [BUF_W-1:0] held_idx,
    output logic [BUF_W-1:0] next_idx
);

    logic [BUF_W:0]   inc1;
    logic [BUF_W:0]   inc2;
    logic [BUF_W-1:0] cand;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        inc1     = {1'b0, wr_idx} + (BUF_W+1)'(1);
        cand     = (inc1 == {1'b0, n}) ? '0 : inc1[BUF_W-1:0];
        inc2     = {1'b0, cand} + (BUF_W+1)'(1);
        next_idx = cand;
        if (rd_lock && (cand == held_idx)) begin
            next_idx = (inc2 == {1'b0, n}) ? '0 : inc2[BUF_W-1:0];
        end
    end

endmodule

// File: rtl/image_store_ring_ctrl.sv
// Sequences the image store writer over a ring of N frame buffers and publishes the
// newest complete buffer to the reader, never starting a write into the held buffer.
module image_store_ring_ctrl
    import image_store_ring_ctrl_pkg::*;
#(
    parameter int BUF_W       = DEFAULT_BUF_W,
    parameter int STORE_WIDTH = 4,
    parameter int FCNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_en,
    input  logic [31:0]            cfg_base,
    input  logic [31:0]            cfg_stride,
    input  logic [BUF_W-1:0]       cfg_buf_num,
    input  logic                   wr_busy,
    output logic                   sig_en,
    output logic [31:0]            sig_address,
    output logic [STORE_WIDTH-1:0] sig_image_cnt,
    input  logic                   rd_lock,
    output logic                   rd_valid,
    output logic [BUF_W-1:0]       rd_index,
    output logic [31:0]            rd_address,
    output logic                   frame_done,
    output logic [FCNT_W-1:0]      frame_cnt,
    output logic                   running
);

    state_t           state;
    state_t           next_state;
    logic [31:0]      base_q;
    logic [31:0]      stride_q;
    logic [BUF_W-1:0] n_q;
    logic [BUF_W-1:0] wr_idx;
    logic [BUF_W-1:0] next_idx;
    logic [BUF_W-1:0] held_idx;
    logic [BUF_W-1:0] held_eff;
    logic             lock_q;
    logic             lock_rise;
    logic [31:0]      commit_addr;

    // A lock rising in the COMMIT cycle already protects the buffer the reader grabbed.
    assign lock_rise = rd_lock && !lock_q;
    assign held_eff  = lock_rise ? rd_index : held_idx;

    image_store_ring_next_idx #(.BUF_W(BUF_W)) u_next_idx (
        .wr_idx   (wr_idx),
        .n        (n_q),
        .rd_lock  (rd_lock),
        .held_idx (held_eff),
        .next_idx (next_idx)
    );

    // Shift-add of the next index times stride, ready before the following ISSUE.
    always_comb begin
        commit_addr = base_q;
        for (int i = 0; i < BUF_W; i++) begin
            if (next_idx[i]) commit_addr = commit_addr + (stride_q << i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (cfg_en)   next_state = ST_ISSUE;
            ST_ISSUE:                   next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (wr_busy)  next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!wr_busy) next_state = ST_COMMIT;
            ST_COMMIT:    next_state = cfg_en ? ST_ISSUE : ST_IDLE;
            default:                    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sig_en        = (state == ST_ISSUE);
        sig_image_cnt = sig_en ? STORE_WIDTH'(CMD_IMAGE_CNT) : '0;
        frame_done    = (state == ST_COMMIT);
        running       = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            stride_q    <= '0;
            n_q         <= '0;
            wr_idx      <= '0;
            sig_address <= '0;
            rd_valid    <= 1'b0;
            rd_index    <= '0;
            rd_address  <= '0;
            frame_cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (cfg_en) begin
                base_q      <= cfg_base;
                stride_q    <= cfg_stride;
                n_q         <= (cfg_buf_num == '0) ? BUF_W'(1) : cfg_buf_num;
                wr_idx      <= '0;
                sig_address <= cfg_base;
                rd_valid    <= 1'b0;
            end
        end else if (state == ST_COMMIT) begin
            rd_index   <= wr_idx;
            rd_address <= sig_address;
            rd_valid   <= 1'b1;
            frame_cnt  <= frame_cnt + FCNT_W'(1);
            wr_idx     <= next_idx;
            if (cfg_en) sig_address <= commit_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= 1'b0;
            held_idx <= '0;
        end else begin
            lock_q <= rd_lock;
            if (lock_rise) held_idx <= rd_index;
        end
    end

endmodule

// File: tb/tb_image_store_ring_ctrl.sv
// Scoreboard bench for image_store_ring_ctrl: a ring model predicts commands and commits,
// a monitor compares them whenever the DUT strobes sig_en or frame_done.
module tb_image_store_ring_ctrl;
    localparam int BUF_W       = 2;
    localparam int STORE_WIDTH = 4;
    localparam int FCNT_W      = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_en;
    logic [31:0]            cfg_base;
    logic [31:0]            cfg_stride;
    logic [BUF_W-1:0]       cfg_buf_num;
    logic                   wr_busy;
    logic                   rd_lock;
    logic                   sig_en;
    logic [31:0]            sig_address;
    logic [STORE_WIDTH-1:0] sig_image_cnt;
    logic                   rd_valid;
    logic [BUF_W-1:0]       rd_index;
    logic [31:0]            rd_address;
    logic                   frame_done;
    logic [FCNT_W-1:0]      frame_cnt;
    logic                   running;

    image_store_ring_ctrl #(.BUF_W(BUF_W), .STORE_WIDTH(STORE_WIDTH), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .cfg_buf_num(cfg_buf_num), .wr_busy(wr_busy), .sig_en(sig_en), .sig_address(sig_address),
        .sig_image_cnt(sig_image_cnt), .rd_lock(rd_lock), .rd_valid(rd_valid), .rd_index(rd_index),
        .rd_address(rd_address), .frame_done(frame_done), .frame_cnt(frame_cnt), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] addr;
        int unsigned cnt;
    } commit_t;

    logic [31:0] cmd_q[$];
    commit_t     commit_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference ring state, kept as plain integers.
    int unsigned m_n, m_wr, m_rd, m_held, m_cnt;
    logic [31:0] m_base, m_stride;

    commit_t mon_cur;
    bit      mon_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_addr(input int unsigned idx);
        return m_base + 32'(idx) * m_stride;
    endfunction

    task automatic model_start();
        m_base   = cfg_base;
        m_stride = cfg_stride;
        m_n      = (cfg_buf_num == '0) ? 1 : int'(cfg_buf_num);
        m_wr     = 0;
        cmd_q.push_back(m_addr(0));
    endtask

    task automatic model_commit();
        int unsigned cand;
        m_cnt = m_cnt + 1;
        commit_q.push_back('{idx: m_wr, addr: m_addr(m_wr), cnt: m_cnt});
        m_rd = m_wr;
        cand = (m_wr + 1) % m_n;
        if (rd_lock && cand == m_held) cand = (cand + 1) % m_n;
        m_wr = cand;
        if (cfg_en) cmd_q.push_back(m_addr(m_wr));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sig_en"},      32'(sig_en), 32'd0);
        check({tag, "_sig_address"}, sig_address, 32'd0);
        check({tag, "_sig_img_cnt"}, 32'(sig_image_cnt), 32'd0);
        check({tag, "_rd_valid"},    32'(rd_valid), 32'd0);
        check({tag, "_rd_index"},    32'(rd_index), 32'd0);
        check({tag, "_rd_address"},  rd_address, 32'd0);
        check({tag, "_frame_done"},  32'(frame_done), 32'd0);
        check({tag, "_frame_cnt"},   32'(frame_cnt), 32'd0);
        check({tag, "_running"},     32'(running), 32'd0);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic start(input int unsigned n, input logic [31:0] base, input logic [31:0] stride);
        cfg_buf_num = BUF_W'(n);
        cfg_base    = base;
        cfg_stride  = stride;
        rd_lock     = 1'b0;
        cfg_en      = 1'b1;
        model_start();
        @(negedge clk);
        check("rd_valid_cleared_on_start", 32'(rd_valid), 32'd0);
    endtask

    task automatic wait_sig_en();
        int t = 0;
        while (!sig_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sig_en) check("sig_en_timeout", 32'(sig_en), 32'd1);
    endtask

    // One frame as the writer sees it; lock_op 1 raises rd_lock, 2 drops it.
    task automatic run_frame(input int len, input int lock_op, input bit drop_en);
        wait_sig_en();
        if (lock_op == 1 && !rd_lock) begin
            rd_lock = 1'b1;
            m_held  = m_rd;
        end else if (lock_op == 2) begin
            rd_lock = 1'b0;
        end
        @(negedge clk);
        wr_busy = 1'b1;
        repeat (len) @(negedge clk);
        if (drop_en) cfg_en = 1'b0;
        wr_busy = 1'b0;
        model_commit();
    endtask

    task automatic settle_idle(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_running_idle"}, 32'(running), 32'd0);
        check({tag, "_rd_valid_kept"}, 32'(rd_valid), 32'd1);
    endtask

    // Monitor: pops expectations whenever the DUT strobes a command or a commit.
    initial begin
        mon_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_pending = 1'b0;
                cmd_q.delete();
                commit_q.delete();
            end else begin
                if (mon_pending) begin
                    check("rd_index",   32'(rd_index), 32'(mon_cur.idx));
                    check("rd_address", rd_address, mon_cur.addr);
                    check("frame_cnt",  32'(frame_cnt), 32'(mon_cur.cnt % (1 << FCNT_W)));
                    check("rd_valid",   32'(rd_valid), 32'd1);
                    mon_pending = 1'b0;
                end
                if (sig_en) begin
                    if (cmd_q.size() == 0) begin
                        check("sig_en_expected", 32'(cmd_q.size() != 0), 32'd1);
                    end else begin
                        check("sig_address", sig_address, cmd_q.pop_front());
                        check("sig_image_cnt", 32'(sig_image_cnt), 32'd1);
                    end
                end
                if (frame_done) begin
                    if (commit_q.size() == 0) begin
                        check("frame_done_expected", 32'(commit_q.size() != 0), 32'd1);
                    end else begin
                        mon_cur     = commit_q.pop_front();
                        mon_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0; cfg_en = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_buf_num = '0;
        wr_busy = 1'b0; rd_lock = 1'b0;
        m_n = 1; m_wr = 0; m_rd = 0; m_held = 0; m_cnt = 0; m_base = '0; m_stride = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Plain ring of three buffers, four frames, then stop.
        start(3, 32'h1000_0000, 32'h0010_0000);
        for (int i = 0; i < 4; i++) run_frame(20, 0, i == 3);
        settle_idle("ring3");
        check("ring3_frame_cnt", 32'(frame_cnt), 32'd4);

        // Lock raised while rd_index = 1: after buffer 0 the writer goes to 2.
        start(3, 32'h1000_0000, 32'h0010_0000);
        run_frame(20, 0, 0);
        run_frame(20, 0, 0);
        run_frame(20, 1, 0);
        run_frame(20, 0, 0);
        run_frame(20, 0, 1);
        settle_idle("lock3");

        // Two buffers with index 0 locked: buffer 1 is rewritten each time.
        start(2, 32'h2000_0000, 32'h0000_8000);
        run_frame(8, 0, 0);
        run_frame(8, 1, 0);
        for (int i = 0; i < 3; i++) run_frame(8, 0, i == 2);
        settle_idle("ring2");

        // Depth 0 behaves as 1; config changes while running are ignored.
        start(0, 32'h0000_0200, 32'h0000_1234);
        run_frame(4, 0, 0);
        cfg_base = 32'hDEAD_0000;
        cfg_buf_num = 2'd3;
        run_frame(4, 0, 0);
        run_frame(4, 1, 0);
        run_frame(4, 0, 1);
        settle_idle("ring1");
        start(0, 32'hDEAD_0000, 32'h0000_1234);
        run_frame(3, 0, 0);
        run_frame(3, 0, 1);
        settle_idle("ring1_restart");

        // Asynchronous reset in WAIT_DONE, then restart with cfg_en held high.
        start(3, 32'h0000_3000, 32'h0000_0040);
        run_frame(5, 0, 0);
        wait_sig_en();
        @(negedge clk);
        wr_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        wr_busy = 1'b0;
        rd_lock = 1'b0;
        m_wr = 0; m_rd = 0; m_held = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        model_start();
        t = 0;
        while (!sig_en && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("sig_en_soon_after_reset", 32'(sig_en && t <= 2), 32'd1);
        run_frame(5, 0, 0);
        run_frame(5, 0, 1);
        settle_idle("post_reset");

        // Randomised ring depths, addresses, busy lengths and lock activity.
        for (int s = 0; s < 4; s++) begin
            start($urandom_range(0, 3), $urandom, $urandom);
            for (int f = 0; f < 8; f++) begin
                run_frame($urandom_range(1, 8), $urandom_range(0, 2), f == 7);
            end
            settle_idle("random");
        end

        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("commit_q_drained", 32'(commit_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
